// File: rtl/data_ram_ws.sv
// data_ram_ws: word-addressed, byte-lane-writable synchronous RAM with a
// configurable number of wait states and a ready/stall handshake toward the
// core's RAM port. Out-of-range accesses complete normally but raise err,
// suppress writes and return zero on reads.
module data_ram_ws #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W/8-1:0]   sel,
   input  logic [DATA_W-1:0]     data_i,
   output logic [DATA_W-1:0]     data_o,
   output logic                  ready,
   output logic                  err,
   output logic                  stall
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int          OFF   = $clog2(DATA_W / 8);
   localparam int          WORDS = 2 ** DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic                    we_q;
   logic                    oor_q;
   logic [LANES-1:0]        sel_q;
   logic [DATA_W-1:0]       data_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [DATA_W-1:0]       mem [WORDS];
   logic                    oor;

   // Any address bit above the word-index field marks the access out of range.
   always_comb begin
      oor = ((addr >> (DEPTH_LOG2 + OFF)) != '0);
   end

   // The core holds off its pipeline until the completion pulse.
   always_comb begin
      stall = ce & ~ready;
   end

   // Request latch, wait-state counter and registered completion outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         we_q   <= 1'b0;
         oor_q  <= 1'b0;
         sel_q  <= '0;
         data_q <= '0;
         idx_q  <= '0;
         data_o <= '0;
         ready  <= 1'b0;
         err    <= 1'b0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ce) begin
                  we_q   <= we;
                  oor_q  <= oor;
                  sel_q  <= sel;
                  data_q <= data_i;
                  idx_q  <= addr[DEPTH_LOG2+OFF-1:OFF];
                  cnt    <= 4'(WAIT_STATES);
                  state  <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               ready <= 1'b1;
               err   <= oor_q;
               if (!we_q) begin
                  data_o <= oor_q ? '0 : mem[idx_q];
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Byte-lane write in the DONE cycle; gated by rst so an edge seen while
   // reset is asserted cannot commit an aborted transaction.
   always_ff @(posedge clk) begin
      if (rst && (state == S_DONE) && we_q && !oor_q) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (sel_q[i]) begin
               mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_ram_ws.sv
// tb_data_ram_ws: directed checks of data_ram_ws with two instances,
// index 1 with WAIT_STATES=2 and index 0 with WAIT_STATES=0.
module tb_data_ram_ws;

   logic        clk;
   logic        rst;
   logic [1:0]  ce;
   logic [1:0]  we;
   logic [1:0]  ready;
   logic [1:0]  err;
   logic [1:0]  stall;
   logic [31:0] addr   [2];
   logic [31:0] data_i [2];
   logic [31:0] data_o [2];
   logic [3:0]  sel    [2];

   int tests;
   int fails;

   data_ram_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .addr(addr[0]), .sel(sel[0]),
      .data_i(data_i[0]), .data_o(data_o[0]), .ready(ready[0]), .err(err[0]),
      .stall(stall[0])
   );

   data_ram_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .addr(addr[1]), .sel(sel[1]),
      .data_i(data_i[1]), .data_o(data_o[1]), .ready(ready[1]), .err(err[1]),
      .stall(stall[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on instance k. lat counts edges after the sampling edge
   // until ready is visible; the core sees it at the following edge.
   task automatic access(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input bit drop,
                         input logic [31:0] a2, input int exp_lat, input string tag,
                         output logic [31:0] rd, output logic e, output logic [7:0] sh);
      int n;
      @(negedge clk);
      ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; data_i[k] = d;
      @(posedge clk); #1;
      n = 0;
      sh = '0;
      sh[0] = stall[k];
      if (drop) begin
         ce[k] = 1'b0; addr[k] = a2; data_i[k] = ~d;
      end
      while (!ready[k] && n < 16) begin
         @(posedge clk); #1;
         n++;
         if (n < 8) sh[n] = stall[k];
      end
      ce[k] = 1'b0;
      rd = data_o[k];
      e  = err[k];
      chk({tag, " latency"}, n, exp_lat);
      @(posedge clk); #1;
      chk({tag, " pulse end"}, {30'd0, ready[k], err[k]}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      logic [7:0]  sh;
      logic        seen;

      tests = 0;
      fails = 0;
      rst = 1'b0;
      ce = '0;
      we = '0;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; data_i[i] = '0; sel[i] = '0;
      end

      // Reset state
      #1;
      chk("reset ws2 outputs", {data_o[1][29:0], ready[1], err[1]}, 32'd0);
      chk("reset ws0 outputs", {data_o[0][29:0], ready[0], err[0]}, 32'd0);
      chk("reset stall", {30'd0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // WAIT_STATES=2 write then read
      access(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 3, "ws2 wr 0x10", rd, e, sh);
      chk("ws2 wr err", {31'd0, e}, 32'd0);
      chk("ws2 wr stall trace", {28'd0, sh[3:0]}, 32'h7);
      access(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 3, "ws2 rd 0x10", rd, e, sh);
      chk("ws2 rd data", rd, 32'hDEADBEEF);
      chk("ws2 rd err", {31'd0, e}, 32'd0);
      chk("ws2 rd stall trace", {28'd0, sh[3:0]}, 32'h7);

      // sel=0 write is a no-op but still completes
      access(1, 1'b1, 32'h10, 4'h0, 32'h00000000, 1'b0, 32'h0, 3, "ws2 wr sel0", rd, e, sh);
      access(1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h0, 3, "ws2 rd after sel0", rd, e, sh);
      chk("sel0 data kept", rd, 32'hDEADBEEF);

      // Byte lanes
      access(1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 32'h0, 3, "ws2 preload 0x20", rd, e, sh);
      access(1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0, 3, "ws2 lane wr", rd, e, sh);
      access(1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 3, "ws2 lane rd", rd, e, sh);
      chk("lane merge data", rd, 32'h11BB33DD);

      // Out of range: 0x1000 would alias word 0 if the high bit were dropped
      access(1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 3, "ws2 preload 0x0", rd, e, sh);
      access(1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 3, "oor wr", rd, e, sh);
      chk("oor wr err", {31'd0, e}, 32'd1);
      access(1, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, 32'h0, 3, "oor rd", rd, e, sh);
      chk("oor rd err", {31'd0, e}, 32'd1);
      chk("oor rd data", rd, 32'h0);
      access(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h0, 3, "rd 0x0 after oor", rd, e, sh);
      chk("no alias data", rd, 32'hCAFEF00D);
      chk("no alias err", {31'd0, e}, 32'd0);

      // ce dropped and addr moved after acceptance
      access(1, 1'b1, 32'h40, 4'hF, 32'h01010101, 1'b0, 32'h0, 3, "preload 0x40", rd, e, sh);
      access(1, 1'b1, 32'h30, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h40, 3, "drop ce wr", rd, e, sh);
      access(1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 32'h0, 3, "rd 0x30", rd, e, sh);
      chk("latched addr data", rd, 32'h5A5A5A5A);
      access(1, 1'b1, 32'h50, 4'hF, 32'h0BADF00D, 1'b0, 32'h0, 3, "preload 0x50", rd, e, sh);
      access(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h0, 3, "rd 0x40", rd, e, sh);
      chk("0x40 untouched", rd, 32'h01010101);

      // Reset during WAIT of a write to 0x50
      @(negedge clk);
      ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h50; sel[1] = 4'hF; data_i[1] = 32'h12345678;
      @(posedge clk); #1;
      ce[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst abort outputs", {data_o[1][29:0], ready[1], err[1]}, 32'd0);
      chk("rst abort data_o", data_o[1], 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst held outputs", {data_o[1][29:0], ready[1], err[1]}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ready[1] || err[1]) seen = 1'b1;
      end
      chk("no ready after abort", {31'd0, seen}, 32'd0);
      access(1, 1'b0, 32'h50, 4'hF, 32'h0, 1'b0, 32'h0, 3, "rd 0x50", rd, e, sh);
      chk("aborted write suppressed", rd, 32'h0BADF00D);

      // WAIT_STATES=0: preload, then back-to-back reads with ce held high
      access(0, 1'b1, 32'h0, 4'hF, 32'h00000A0A, 1'b0, 32'h0, 1, "ws0 wr 0x0", rd, e, sh);
      access(0, 1'b1, 32'h4, 4'hF, 32'h00000B0B, 1'b0, 32'h0, 1, "ws0 wr 0x4", rd, e, sh);
      @(negedge clk);
      ce[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0; sel[0] = 4'hF;
      @(posedge clk); #1;
      addr[0] = 32'h4;
      chk("b2b e0 ready", {31'd0, ready[0]}, 32'd0);
      @(posedge clk); #1;
      chk("b2b e1 ready", {31'd0, ready[0]}, 32'd1);
      chk("b2b e1 data", data_o[0], 32'h00000A0A);
      @(posedge clk); #1;
      chk("b2b e2 ready", {31'd0, ready[0]}, 32'd0);
      chk("b2b e2 stall", {31'd0, stall[0]}, 32'd1);
      @(posedge clk); #1;
      ce[0] = 1'b0;
      chk("b2b e3 ready", {31'd0, ready[0]}, 32'd1);
      chk("b2b e3 data", data_o[0], 32'h00000B0B);
      @(posedge clk); #1;
      chk("b2b end ready", {31'd0, ready[0]}, 32'd0);
      chk("b2b data held", data_o[0], 32'h00000B0B);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
